sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
- Command-side counterpart of the team's gated S/R latch: converts a handshaked "set/reset" request stream into clean, timed s/r/e control pulses for one latch.
- Guarantees the illegal s=r=1 combination is never driven, holds e for a programmable width, then enforces a recovery gap before the next command.
- Keeps a registered model of the latch state, so redundant requests are skipped unless forced.
- Sits between control FSMs and any SR-latch instance.

Parameters:
- PULSE_W, 2, cycles e and s/r are held high per pulse; legal range 1..255.
- GAP_W, 1, idle cycles with e=0 after each pulse before the next accept; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  command valid
- req_ready  output  1  block can accept a command this cycle
- req_val  input  1  1=set latch, 0=reset latch
- req_force  input  1  1=pulse even when the model already equals req_val
- s  output  1  latch set drive, registered
- r  output  1  latch reset drive, registered
- e  output  1  latch enable, registered
- q_model  output  1  modelled latch state
- busy  output  1  high in PULSE or GAP
- done  output  1  one-cycle completion strobe per accepted command

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst. All outputs are registered except req_ready.
- Reset values: s=0, r=0, e=0, q_model=0, busy=0, done=0. State is IDLE and the counter is 0.
- req_ready = (state==IDLE) && !rst. Accept happens when req_valid && req_ready on a clock edge.
- States:
  - IDLE: on accept with req_force=1 or req_val!=q_model, latch cmd=req_val, load cnt=PULSE_W-1, go to PULSE. On accept with req_val==q_model and req_force=0 (skip), stay in IDLE and assert done on the next cycle. No pulse is driven.
  - PULSE: e=1, s=cmd, r=!cmd. Decrement cnt each cycle. At cnt==0, go to GAP (load GAP_W-1) or to IDLE if GAP_W==0. At this same transition, set q_model<=cmd and done<=1 for one cycle.
  - GAP: s=r=e=0, busy=1. Decrement cnt. At cnt==0, go to IDLE.
- Timing: accept at edge n drives s/r/e high for edges n+1..n+PULSE_W. done and the q_model update appear at edge n+PULSE_W+1. req_ready returns at edge n+PULSE_W+GAP_W+1.
- Invariants, every cycle:
  - s&r == 0.
  - (s|r) implies e.
  - e implies exactly one of s or r.
- req_val and req_force are sampled only at accept. Changes during PULSE or GAP are ignored. Requests are never queued; the requester holds req_valid until it sees req_ready.
- Back-to-back: with GAP_W=0, a new command can be accepted in the cycle done is high, since state is IDLE then.
- Reset mid-PULSE: at the next edge s/r/e drop to 0 and q_model goes to 0, even if the physical latch was partly driven. The system must re-issue a forced command after reset.
- Counter width is 8 bits. Parameter values outside the legal range are a compile-time error (generate-time check).

Decomposition:
- Package sr_drv_pkg holds:
  - state enum {IDLE, PULSE, GAP} (2 bits)
  - CMD_SET=1'b1, CMD_RST=1'b0
  - CNT_W=8
- No RTL sub-module is needed; the counter is inline.
- The testbench instantiates the existing SR latch, driven by s/r/e, as a reference model and checks q against q_model after done.

Test Plan:
- Reset then idle: rst high 2 cycles -> s=r=e=0, q_model=0, req_ready=1, busy=0.
- Set command, PULSE_W=2, GAP_W=1: req_val=1 accepted at cycle 5 -> s=e=1 at cycles 6-7; done and q_model=1 at cycle 8; req_ready=0 cycles 6-8, =1 at cycle 9; the latch model's q=1.
- Redundant skip: q_model=1, req_val=1, req_force=0 -> no s/r/e activity, done=1 the next cycle, req_ready stays 1. Same request with req_force=1 -> full 2-cycle set pulse.
- Reset command plus back-to-back with GAP_W=0: set then reset accepted in the done cycle -> r=e=1 for 2 cycles immediately after, q_model=0. The s&r==0 assertion holds throughout.
- Reset mid-pulse: rst asserted at the 1st PULSE cycle -> the next edge shows s=r=e=0, q_model=0, req_ready=1 after rst drops. No done is emitted.
- Inputs changing during busy: toggle req_val/req_force while in PULSE/GAP -> no effect on s/r/done. A random 1000-command run with PULSE_W=1, GAP_W=3 has zero invariant violations.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch command driver.
// Imported by the driver top and its bench.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic CMD_SET = 1'b1;
  localparam logic CMD_RST = 1'b0;

  localparam int CNT_W = 8;

endpackage

// File: rtl/sr_latch_driver.sv
// Turns handshaked set/reset requests into timed s/r/e pulses for one
// gated SR latch, never driving s=r=1, and tracks the latch in q_model.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_val,
  input  logic req_force,
  output logic s,
  output logic r,
  output logic e,
  output logic q_model,
  output logic busy,
  output logic done
);

  if (PULSE_W < 1 || PULSE_W > 255) begin : g_bad_pulse
    $fatal(1, "sr_latch_driver: PULSE_W must be 1..255");
  end
  if (GAP_W < 0 || GAP_W > 255) begin : g_bad_gap
    $fatal(1, "sr_latch_driver: GAP_W must be 0..255");
  end

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD =
    (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             cmd;
  logic             cmd_n;
  logic             q_n;
  logic             done_n;
  logic             s_n;
  logic             r_n;
  logic             e_n;
  logic             busy_n;
  logic             accept;
  logic             pulse_req;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  // A request matching the modelled state is skipped unless forced.
  assign pulse_req = req_force || (req_val != q_model);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cmd     <= CMD_RST;
      q_model <= 1'b0;
      done    <= 1'b0;
      s       <= 1'b0;
      r       <= 1'b0;
      e       <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cmd     <= cmd_n;
      q_model <= q_n;
      done    <= done_n;
      s       <= s_n;
      r       <= r_n;
      e       <= e_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cmd_n   = cmd;
    q_n     = q_model;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (pulse_req) begin
            state_n = PULSE;
            cnt_n   = PULSE_LD;
            cmd_n   = req_val;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          q_n    = cmd;
          done_n = 1'b1;
          if (GAP_W == 0) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = GAP;
            cnt_n   = GAP_LD;
          end
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so s and r can never
  // overlap and always sit inside the e window.
  always_comb begin
    e_n    = (state_n == PULSE);
    s_n    = e_n && (cmd_n == CMD_SET);
    r_n    = e_n && (cmd_n == CMD_RST);
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: vector table, back-to-back sequence and a
// randomized run against a cycle-schedule reference model.
module tb_sr_latch_driver;

  typedef struct packed {
    logic s;
    logic r;
    logic e;
    logic q;
    logic busy;
    logic done;
    logic rdy;
  } ob_t;

  typedef struct packed {
    logic rst;
    logic v;
    logic val;
    logic f;
    ob_t  exp;
  } row_t;

  localparam int RPW = 1;
  localparam int RGW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rv = '0;
  logic [2:0] rval = '0;
  logic [2:0] rf = '0;
  logic [2:0] rdy;
  logic [2:0] s;
  logic [2:0] r;
  logic [2:0] e;
  logic [2:0] qm;
  logic [2:0] busy;
  logic [2:0] done;

  logic [2:0] q_lat = '0;
  int tests = 0;
  int fails = 0;
  int viol = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sr_latch_driver #(
      .PULSE_W(g == 2 ? RPW : 2),
      .GAP_W  (g == 0 ? 1 : (g == 1 ? 0 : RGW))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(rv[g]),
      .req_ready(rdy[g]),
      .req_val  (rval[g]),
      .req_force(rf[g]),
      .s        (s[g]),
      .r        (r[g]),
      .e        (e[g]),
      .q_model  (qm[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

  function automatic ob_t obs(int g);
    return {s[g], r[g], e[g], qm[g], busy[g], done[g], rdy[g]};
  endfunction

  task automatic chk(string nm, ob_t got, ob_t need);
    tests++;
    if (got !== need) begin
      fails++;
      $display("FAIL %s got %b need %b", nm, got, need);
    end
  endtask

  // Per-cycle monitor: gated SR latch reference plus invariants.
  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (!rst && done[g]) begin
        tests++;
        if (q_lat[g] !== qm[g]) begin
          fails++;
          $display("FAIL latch_q%0d got %b need %b", g, qm[g], q_lat[g]);
        end
      end
      if ((s[g] & r[g]) || ((s[g] | r[g]) & ~e[g]) ||
          (e[g] & ~(s[g] ^ r[g])))
        viol++;
      if (e[g] && s[g] && !r[g]) q_lat[g] = 1'b1;
      else if (e[g] && r[g] && !s[g]) q_lat[g] = 1'b0;
    end
  endtask

  row_t tbl [25];
  ob_t  sbq [$];
  ob_t  ex;
  ob_t  ent;
  logic qref;
  logic qcur;
  int   ncmd;
  int   cyc;

  initial begin
    // {rst v val f} {s r e q busy done rdy} for instance 0 (2,1)
    tbl[0]  = {4'b1000, 7'b0000000};
    tbl[1]  = {4'b1000, 7'b0000000};
    tbl[2]  = {4'b0000, 7'b0000001};
    tbl[3]  = {4'b0110, 7'b1010100};
    tbl[4]  = {4'b0000, 7'b1010100};
    tbl[5]  = {4'b0000, 7'b0001110};
    tbl[6]  = {4'b0000, 7'b0001001};
    tbl[7]  = {4'b0110, 7'b0001011};
    tbl[8]  = {4'b0000, 7'b0001001};
    tbl[9]  = {4'b0111, 7'b1011100};
    tbl[10] = {4'b0001, 7'b1011100};
    tbl[11] = {4'b0100, 7'b0001110};
    tbl[12] = {4'b0011, 7'b0001001};
    tbl[13] = {4'b0100, 7'b0111100};
    tbl[14] = {4'b0000, 7'b0111100};
    tbl[15] = {4'b0000, 7'b0000110};
    tbl[16] = {4'b0000, 7'b0000001};
    tbl[17] = {4'b0110, 7'b1010100};
    tbl[18] = {4'b0000, 7'b1010100};
    tbl[19] = {4'b0000, 7'b0001110};
    tbl[20] = {4'b0000, 7'b0001001};
    tbl[21] = {4'b0100, 7'b0111100};
    tbl[22] = {4'b1000, 7'b0000000};
    tbl[23] = {4'b0000, 7'b0000001};
    tbl[24] = {4'b0000, 7'b0000001};

    for (int i = 0; i < 25; i++) begin
      rst     = tbl[i].rst;
      rv[0]   = tbl[i].v;
      rval[0] = tbl[i].val;
      rf[0]   = tbl[i].f;
      tick();
      chk($sformatf("row%0d", i), obs(0), tbl[i].exp);
    end
    rv[0] = 1'b0;

    // Back-to-back on instance 1 (2,0): reset accepted in the done cycle.
    rv[1] = 1'b1; rval[1] = 1'b1; rf[1] = 1'b0;
    tick(); chk("b2b_set1", obs(1), 7'b1010100);
    rval[1] = 1'b0;
    tick(); chk("b2b_set2", obs(1), 7'b1010100);
    tick(); chk("b2b_done1", obs(1), 7'b0001011);
    tick(); chk("b2b_rst1", obs(1), 7'b0111100);
    rv[1] = 1'b0;
    tick(); chk("b2b_rst2", obs(1), 7'b0111100);
    tick(); chk("b2b_done2", obs(1), 7'b0000011);
    tick(); chk("b2b_idle", obs(1), 7'b0000001);

    // Random run on instance 2 against a cycle schedule.
    qref = 1'b0;
    ncmd = 0;
    cyc  = 0;
    while (ncmd < 1000 && cyc < 20000) begin
      ex = (sbq.size() != 0) ? sbq.pop_front()
                             : {3'b000, qref, 3'b001};
      chk($sformatf("rand_c%0d", cyc), obs(2), ex);
      rv[2]   = 1'($urandom_range(0, 1));
      rval[2] = 1'($urandom_range(0, 1));
      rf[2]   = ($urandom_range(0, 3) == 0);
      if (rv[2] && ex.rdy) begin
        ncmd++;
        qcur = ex.q;
        if (rf[2] || rval[2] != qcur) begin
          for (int k = 0; k < RPW; k++) begin
            ent = {rval[2], ~rval[2], 1'b1, qcur, 3'b100};
            sbq.push_back(ent);
          end
          for (int k = 0; k < RGW; k++) begin
            ent = {3'b000, rval[2], 1'b1, (k == 0), 1'b0};
            sbq.push_back(ent);
          end
          if (RGW == 0) begin
            ent = {3'b000, rval[2], 3'b011};
            sbq.push_back(ent);
          end
          qref = rval[2];
        end else begin
          ent = {3'b000, qcur, 3'b011};
          sbq.push_back(ent);
        end
      end
      tick();
      cyc++;
    end
    rv[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ex = (sbq.size() != 0) ? sbq.pop_front()
                             : {3'b000, qref, 3'b001};
      chk($sformatf("drain%0d", k), obs(2), ex);
      tick();
    end

    tests++;
    if (ncmd < 1000) begin
      fails++;
      $display("FAIL rand_budget got %0d cmds need 1000", ncmd);
    end
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL invariants got %0d violations need 0", viol);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
